// File: rtl/sw_input_ctrl.sv
// ---------------------------------------------------------------------------
// sw_input_ctrl
//
// Memory-mapped switch input peripheral. Raw switch levels are synchronised,
// debounced on a slow sample tick, and edge events are latched into
// write-1-to-clear RISE/FALL registers that can raise a level interrupt.
//
// Register window (word index = addr[7:2]):
//   0x00 STATE  debounced levels             (RO)
//   0x04 RISE   0->1 events                  (W1C)
//   0x08 FALL   1->0 events                  (W1C)
//   0x0C IRQ_EN interrupt enable per switch  (RW)
//   0x10 RAW    synchronised raw levels      (RO)
//   others read 0, stores ignored
//
// Ports:
//   clk_i    - clock, all state updates on rising edge
//   rst_ni   - asynchronous active-low reset
//   st_en    - store strobe (already address-qualified)
//   funct3   - store size: 0 byte, 1 half, anything else word
//   addr     - byte offset inside the register window
//   st_data  - right-aligned store data
//   i_io_sw  - asynchronous raw switch levels
//   ld_data  - combinational read data for addr
//   o_irq    - level interrupt: any enabled pending RISE/FALL bit
// ---------------------------------------------------------------------------
module sw_input_ctrl #(
    parameter int SW_W       = 17,
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            st_en,
    input  logic [2:0]      funct3,
    input  logic [7:0]      addr,
    input  logic [31:0]     st_data,
    input  logic [SW_W-1:0] i_io_sw,
    output logic [31:0]     ld_data,
    output logic            o_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]    CNT_MAX   = 3'(DB_SAMPLES - 1);

    // Bits at or above SW_W are forced to zero in every 32-bit register.
    localparam logic [31:0] VALID_MASK =
        (SW_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << SW_W) - 32'd1);

    localparam logic [5:0] IDX_STATE  = 6'd0;
    localparam logic [5:0] IDX_RISE   = 6'd1;
    localparam logic [5:0] IDX_FALL   = 6'd2;
    localparam logic [5:0] IDX_IRQ_EN = 6'd3;
    localparam logic [5:0] IDX_RAW    = 6'd4;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser
    // -----------------------------------------------------------------------
    logic [SW_W-1:0] sync1_reg;
    logic [SW_W-1:0] sync2_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= i_io_sw;
            sync2_reg <= sync1_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Free-running sample prescaler
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    logic          tick;

    assign tick = (presc_reg == PRESC_MAX);

    always_comb begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // -----------------------------------------------------------------------
    // Per-switch debouncer: a change is accepted only after DB_SAMPLES
    // consecutive ticks that all disagree with the current debounced level.
    // -----------------------------------------------------------------------
    logic [SW_W-1:0] db_level;

    genvar gi;
    generate
        for (gi = 0; gi < SW_W; gi++) begin : g_db
            logic       db_bit_reg;
            logic       db_bit_next;
            logic [2:0] cnt_reg;
            logic [2:0] cnt_next;

            always_comb begin
                db_bit_next = db_bit_reg;
                cnt_next    = cnt_reg;
                if (tick) begin
                    if (sync2_reg[gi] == db_bit_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        db_bit_next = ~db_bit_reg;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    db_bit_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    db_bit_reg <= db_bit_next;
                    cnt_reg    <= cnt_next;
                end
            end

            assign db_level[gi] = db_bit_reg;
        end
    endgenerate

    // Delayed copy of the debounced level: an edge seen between db_level and
    // this copy is latched into RISE/FALL one edge after db_level changes.
    logic [SW_W-1:0] db_d_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_d_reg <= '0;
        end else begin
            db_d_reg <= db_level;
        end
    end

    logic [31:0] rise_set;
    logic [31:0] fall_set;

    assign rise_set = 32'(db_level & ~db_d_reg);
    assign fall_set = 32'(~db_level & db_d_reg);

    // -----------------------------------------------------------------------
    // Store lane decode
    // -----------------------------------------------------------------------
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wmask;

    always_comb begin
        be    = 4'b0000;
        wdata = '0;
        case (funct3)
            3'd0: begin
                be    = 4'b0001 << addr[1:0];
                wdata = 32'(st_data[7:0]) << {addr[1:0], 3'b000};
            end
            3'd1: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = 32'(st_data[15:0]) << {addr[1], 4'b0000};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{be[gi]}};
        end
    endgenerate

    logic [5:0] word_idx;
    logic       wr_rise;
    logic       wr_fall;
    logic       wr_irq_en;

    assign word_idx  = addr[7:2];
    assign wr_rise   = st_en && (word_idx == IDX_RISE);
    assign wr_fall   = st_en && (word_idx == IDX_FALL);
    assign wr_irq_en = st_en && (word_idx == IDX_IRQ_EN);

    // -----------------------------------------------------------------------
    // RISE / FALL / IRQ_EN registers
    // -----------------------------------------------------------------------
    logic [31:0] rise_reg,   rise_next;
    logic [31:0] fall_reg,   fall_next;
    logic [31:0] irq_en_reg, irq_en_next;
    logic [31:0] w1c_bits;

    assign w1c_bits = wdata & wmask;

    always_comb begin
        rise_next   = rise_reg;
        fall_next   = fall_reg;
        irq_en_next = irq_en_reg;
        if (wr_rise) begin
            rise_next = rise_reg & ~w1c_bits;
        end
        if (wr_fall) begin
            fall_next = fall_reg & ~w1c_bits;
        end
        if (wr_irq_en) begin
            irq_en_next = (irq_en_reg & ~wmask) | (wdata & wmask);
        end
        // New events are OR'd in last so they win over a same-cycle clear.
        rise_next   = (rise_next | rise_set) & VALID_MASK;
        fall_next   = (fall_next | fall_set) & VALID_MASK;
        irq_en_next = irq_en_next & VALID_MASK;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_reg   <= '0;
            fall_reg   <= '0;
            irq_en_reg <= '0;
        end else begin
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
            irq_en_reg <= irq_en_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux and interrupt
    // -----------------------------------------------------------------------
    always_comb begin
        ld_data = '0;
        case (word_idx)
            IDX_STATE:  ld_data = 32'(db_level);
            IDX_RISE:   ld_data = rise_reg;
            IDX_FALL:   ld_data = fall_reg;
            IDX_IRQ_EN: ld_data = irq_en_reg;
            IDX_RAW:    ld_data = 32'(sync2_reg);
            default:    ld_data = '0;
        endcase
    end

    assign o_irq = |((rise_reg | fall_reg) & irq_en_reg);

endmodule

// File: tb/tb_sw_input_ctrl.sv
module tb_sw_input_ctrl;

    localparam int SW_W = 17;

    logic            clk     = 1'b0;
    logic            rst_ni  = 1'b0;
    logic            st_en   = 1'b0;
    logic [2:0]      funct3  = 3'd0;
    logic [7:0]      addr    = 8'd0;
    logic [31:0]     st_data = 32'd0;
    logic [SW_W-1:0] sw      = '0;
    logic [31:0]     ld_data;
    logic            o_irq;

    int checks   = 0;
    int failures = 0;

    sw_input_ctrl #(
        .SW_W      (SW_W),
        .TICK_DIV  (4),
        .DB_SAMPLES(3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .st_en  (st_en),
        .funct3 (funct3),
        .addr   (addr),
        .st_data(st_data),
        .i_io_sw(sw),
        .ld_data(ld_data),
        .o_irq  (o_irq)
    );

    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=no finish required=finish before timeout");
        $fatal(1, "watchdog");
    end

    // Scoreboard of expected observations
    typedef struct {
        string       tag;
        bit          is_irq;
        logic [7:0]  a;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_rd(input string tag, input logic [7:0] a, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.is_irq = 1'b0; x.a = a; x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic expect_irq(input string tag, input logic e);
        exp_t x;
        x.tag = tag; x.is_irq = 1'b1; x.a = 8'd0; x.exp = {31'd0, e};
        sb_q.push_back(x);
    endtask

    task automatic check_all();
        exp_t x;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            if (!x.is_irq) addr = x.a;
            #1;
            obs = x.is_irq ? {31'd0, o_irq} : ld_data;
            checks++;
            assert (obs === x.exp) else begin
                failures++;
                $error("FAIL %s: observed=0x%08h expected=0x%08h", x.tag, obs, x.exp);
            end
            $display("check %s: observed=0x%08h expected=0x%08h", x.tag, obs, x.exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
        $display("check %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    endtask

    // Poll a register each negedge until (ld_data & mask) == val, bounded.
    task automatic wait_bits(input string tag, input logic [7:0] a, input logic [31:0] mask,
                             input logic [31:0] val, input int maxc, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < maxc) begin
            @(negedge clk);
            n++;
            addr = a;
            #1;
            if ((ld_data & mask) === val) hit = 1'b1;
        end
        checks++;
        assert (hit) else begin
            failures++;
            $error("FAIL %s: observed=timeout after %0d cycles expected=0x%08h", tag, n, val);
        end
        $display("wait %s: cycles=%0d hit=%0d", tag, n, hit);
    endtask

    task automatic store_now(input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
        st_en   = 1'b1;
        funct3  = f;
        addr    = a;
        st_data = d;
        @(posedge clk);
        #1;
        st_en   = 1'b0;
        $display("store f3=%0d addr=0x%02h data=0x%08h", f, a, d);
    endtask

    task automatic store(input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        store_now(f, a, d);
    endtask

    initial begin
        int n;

        // ---------------- reset state (switches high while in reset) -------
        sw = '1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) expect_rd("rst_read", 8'(i * 4), 32'h0);
        expect_irq("rst_irq", 1'b0);
        check_all();
        sw = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- sw[0] rise: sync latency and debounce ------------
        @(negedge clk);
        sw[0] = 1'b1;
        @(negedge clk);
        expect_rd("raw_1clk", 8'h10, 32'h0);
        check_all();
        @(negedge clk);
        expect_rd("raw_2clk", 8'h10, 32'h1);
        check_all();
        wait_bits("state_b0", 8'h00, 32'h1, 32'h1, 20, n);
        check_int("state_b0_latency", n + 2, 11, 14);
        expect_rd("rise_not_yet", 8'h04, 32'h0);
        check_all();
        @(negedge clk);
        expect_rd("rise_b0", 8'h04, 32'h1);
        expect_rd("state_b0_only", 8'h00, 32'h1);
        check_all();

        // ---------------- IRQ enable / W1C ---------------------------------
        expect_irq("irq_disabled", 1'b0);
        check_all();
        store(3'd2, 8'h0C, 32'h1);
        expect_rd("irq_en_w", 8'h0C, 32'h1);
        expect_irq("irq_on", 1'b1);
        check_all();
        store(3'd1, 8'h0E, 32'h0000_0001);
        expect_rd("irq_en_sh_hi", 8'h0C, 32'h0001_0001);
        check_all();
        store(3'd2, 8'h04, 32'h1);
        expect_rd("rise_w1c", 8'h04, 32'h0);
        expect_irq("irq_off", 1'b0);
        check_all();

        // ---------------- boundaries: width mask, RO, unmapped -------------
        store(3'd7, 8'h0C, 32'hFFFF_FFFF);
        expect_rd("irq_en_width", 8'h0C, 32'h0001_FFFF);
        check_all();
        store(3'd2, 8'h00, 32'h0000_FFFE);
        store(3'd2, 8'h10, 32'h0000_FFFF);
        store(3'd2, 8'h14, 32'hFFFF_FFFF);
        expect_rd("state_ro", 8'h00, 32'h1);
        expect_rd("raw_ro", 8'h10, 32'h1);
        expect_rd("unmapped", 8'h14, 32'h0);
        expect_rd("unmapped_hi", 8'hFC, 32'h0);
        check_all();
        store(3'd7, 8'h0C, 32'h0);
        expect_rd("irq_en_clear", 8'h0C, 32'h0);
        check_all();

        // ---------------- sw[3] one-tick glitch ----------------------------
        @(negedge clk);
        sw[3] = 1'b1;
        repeat (4) @(negedge clk);
        sw[3] = 1'b0;
        repeat (24) @(negedge clk);
        expect_rd("glitch_state", 8'h00, 32'h1);
        expect_rd("glitch_rise", 8'h04, 32'h0);
        check_all();

        // ---------------- FALL W1C with byte/half lanes ---------------------
        @(negedge clk);
        sw[9:8] = 2'b11;
        wait_bits("state_b98", 8'h00, 32'h300, 32'h300, 20, n);
        repeat (2) @(negedge clk);
        sw[9:8] = 2'b00;
        wait_bits("fall_b98", 8'h08, 32'h300, 32'h300, 24, n);
        expect_rd("fall_0300", 8'h08, 32'h300);
        check_all();
        store(3'd0, 8'h0A, 32'h0000_00FF);
        expect_rd("fall_sb_lane2", 8'h08, 32'h300);
        check_all();
        store(3'd2, 8'h08, 32'h0);
        expect_rd("fall_w0", 8'h08, 32'h300);
        check_all();
        store(3'd0, 8'h09, 32'h0000_0002);
        expect_rd("fall_sb_09", 8'h08, 32'h100);
        check_all();
        store(3'd1, 8'h08, 32'h0000_FFFF);
        expect_rd("fall_sh_08", 8'h08, 32'h0);
        check_all();
        store(3'd2, 8'h04, 32'h0001_FFFF);
        expect_rd("rise_clear_all", 8'h04, 32'h0);
        check_all();

        // ---------------- set beats same-cycle W1C on bit5 ------------------
        @(negedge clk);
        sw[5] = 1'b1;
        wait_bits("state_b5", 8'h00, 32'h20, 32'h20, 20, n);
        expect_rd("rise_b5_pre", 8'h04, 32'h0);
        check_all();
        store_now(3'd2, 8'h04, 32'h20);
        expect_rd("rise_b5_set_wins", 8'h04, 32'h20);
        check_all();
        store(3'd2, 8'h0C, 32'h20);
        expect_irq("irq_b5", 1'b1);
        check_all();

        // ---------------- reset mid-count with sw[16] held ------------------
        @(negedge clk);
        sw = 17'h1_0000;
        repeat (6) @(negedge clk);
        rst_ni = 1'b0;
        for (int i = 0; i < 6; i++) expect_rd("rst2_read", 8'(i * 4), 32'h0);
        expect_irq("rst2_irq", 1'b0);
        check_all();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        wait_bits("state_b16", 8'h00, 32'h1_0000, 32'h1_0000, 30, n);
        check_int("state_b16_edges", n, 12, 12);
        @(negedge clk);
        expect_rd("rise_b16", 8'h04, 32'h1_0000);
        expect_rd("state_b16", 8'h00, 32'h1_0000);
        expect_rd("fall_none", 8'h08, 32'h0);
        expect_irq("irq_after_rst", 1'b0);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
